// File: rtl/backward_batch.sv
// backward_batch: five-stage backpropagation pipeline for a two-layer sigmoid network.
// Gradients are summed over BATCH samples and offered to the consumer through a valid/ack handshake.
module backward_batch #(
   parameter int N_IN  = 2,
   parameter int N_HID = 3,
   parameter int N_OUT = 2,
   parameter int W     = 16,
   parameter int FRAC  = 10,
   parameter int BATCH = 4
) (
   input  logic                     clk,
   input  logic                     res,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [N_IN*W-1:0]        k,
   input  logic [N_HID*W-1:0]       a2,
   input  logic [N_OUT*W-1:0]       a3,
   input  logic [N_OUT*W-1:0]       t,
   input  logic [N_HID*N_OUT*W-1:0] w3,
   output logic                     grad_valid,
   input  logic                     grad_ack,
   output logic [N_HID*N_OUT*W-1:0] grad_w3,
   output logic [N_IN*N_HID*W-1:0]  grad_w2,
   output logic [N_OUT*W-1:0]       grad_b3,
   output logic [N_HID*W-1:0]       grad_b2,
   output logic                     busy
);
   localparam int NW3 = N_HID * N_OUT;
   localparam int NW2 = N_IN * N_HID;
   localparam int AW  = W + $clog2(BATCH) + 1;
   localparam int XW  = 2 * W + 8;
   localparam int CW  = $clog2(BATCH) + 1;
   localparam logic [1:0] ACCUM = 2'd0;
   localparam logic [1:0] DRAIN = 2'd1;
   localparam logic [1:0] HOLD  = 2'd2;

   typedef logic signed [XW-1:0] wide_t;
   localparam wide_t ONE = wide_t'(1) <<< FRAC;

   function automatic wide_t wx(input logic [W-1:0] x);
      wx = wide_t'($signed(x));
   endfunction

   function automatic logic [W-1:0] sat(input wide_t v);
      wide_t hi;
      hi = wide_t'({1'b0, {(W-1){1'b1}}});
      if (v > hi)       sat = {1'b0, {(W-1){1'b1}}};
      else if (v < ~hi) sat = {1'b1, {(W-1){1'b0}}};
      else              sat = v[W-1:0];
   endfunction

   // Fixed-point product: floor of the full-width product shifted down, then clamped.
   function automatic logic [W-1:0] mul(input logic [W-1:0] x, input logic [W-1:0] y);
      logic signed [2*W-1:0] p;
      p   = (2*W)'($signed(x)) * (2*W)'($signed(y));
      mul = sat(wide_t'(p >>> FRAC));
   endfunction

   typedef struct packed {
      logic [4:0]         v;
      logic [N_OUT*W-1:0] s1_dadz3, s1_err;
      logic [N_HID*W-1:0] s1_dadz2, s1_a2;
      logic [N_IN*W-1:0]  s1_k;
      logic [NW3*W-1:0]   s1_w3;
      logic [N_OUT*W-1:0] s2_delta3;
      logic [N_HID*W-1:0] s2_dadz2, s2_a2;
      logic [N_IN*W-1:0]  s2_k;
      logic [NW3*W-1:0]   s2_w3;
      logic [N_HID*W-1:0] s3_e2, s3_dadz2, s3_a2;
      logic [N_OUT*W-1:0] s3_delta3;
      logic [N_IN*W-1:0]  s3_k;
      logic [N_HID*W-1:0] s4_delta2, s4_a2;
      logic [N_OUT*W-1:0] s4_delta3;
      logic [N_IN*W-1:0]  s4_k;
      logic [NW3*W-1:0]   s5_dw3;
      logic [NW2*W-1:0]   s5_dw2;
      logic [N_OUT*W-1:0] s5_delta3;
      logic [N_HID*W-1:0] s5_delta2;
   } pipe_t;

   typedef struct packed {
      logic [NW3*AW-1:0]   w3;
      logic [NW2*AW-1:0]   w2;
      logic [N_OUT*AW-1:0] b3;
      logic [N_HID*AW-1:0] b2;
   } acc_t;

   logic [1:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   pipe_t         pipe_q, pipe_d;
   acc_t          acc_q, acc_d;
   logic          accept;

   assign in_ready   = (state_q == ACCUM);
   assign accept     = in_valid & in_ready;
   assign grad_valid = (state_q == HOLD);
   assign busy       = (state_q != ACCUM) | (|pipe_q.v);

   always_comb begin
      wide_t sum;
      sum      = '0;
      pipe_d   = pipe_q;
      pipe_d.v = {pipe_q.v[3:0], accept};
      pipe_d.s1_a2 = a2;
      pipe_d.s1_k  = k;
      pipe_d.s1_w3 = w3;
      for (int j = 0; j < N_OUT; j++) begin
         pipe_d.s1_dadz3[j*W +: W] = mul(a3[j*W +: W], sat(ONE - wx(a3[j*W +: W])));
         pipe_d.s1_err[j*W +: W]   = sat(wx(a3[j*W +: W]) - wx(t[j*W +: W]));
         pipe_d.s2_delta3[j*W +: W] = mul(pipe_q.s1_err[j*W +: W], pipe_q.s1_dadz3[j*W +: W]);
      end
      for (int i = 0; i < N_HID; i++)
         pipe_d.s1_dadz2[i*W +: W] = mul(a2[i*W +: W], sat(ONE - wx(a2[i*W +: W])));
      pipe_d.s2_dadz2 = pipe_q.s1_dadz2;
      pipe_d.s2_a2    = pipe_q.s1_a2;
      pipe_d.s2_k     = pipe_q.s1_k;
      pipe_d.s2_w3    = pipe_q.s1_w3;
      // Hidden-layer error: weighted sum of output deltas back through w3.
      for (int i = 0; i < N_HID; i++) begin
         sum = '0;
         for (int j = 0; j < N_OUT; j++)
            sum = sum + wx(mul(pipe_q.s2_w3[(i*N_OUT+j)*W +: W], pipe_q.s2_delta3[j*W +: W]));
         pipe_d.s3_e2[i*W +: W]     = sat(sum);
         pipe_d.s4_delta2[i*W +: W] = mul(pipe_q.s3_e2[i*W +: W], pipe_q.s3_dadz2[i*W +: W]);
      end
      pipe_d.s3_delta3 = pipe_q.s2_delta3;
      pipe_d.s3_dadz2  = pipe_q.s2_dadz2;
      pipe_d.s3_a2     = pipe_q.s2_a2;
      pipe_d.s3_k      = pipe_q.s2_k;
      pipe_d.s4_delta3 = pipe_q.s3_delta3;
      pipe_d.s4_a2     = pipe_q.s3_a2;
      pipe_d.s4_k      = pipe_q.s3_k;
      pipe_d.s5_delta3 = pipe_q.s4_delta3;
      pipe_d.s5_delta2 = pipe_q.s4_delta2;
      for (int i = 0; i < N_HID; i++)
         for (int j = 0; j < N_OUT; j++)
            pipe_d.s5_dw3[(i*N_OUT+j)*W +: W] = mul(pipe_q.s4_delta3[j*W +: W], pipe_q.s4_a2[i*W +: W]);
      for (int j = 0; j < N_IN; j++)
         for (int i = 0; i < N_HID; i++)
            pipe_d.s5_dw2[(j*N_HID+i)*W +: W] = mul(pipe_q.s4_delta2[i*W +: W], pipe_q.s4_k[j*W +: W]);
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ACCUM: if (accept) begin
            if (cnt_q == CW'(BATCH - 1)) begin
               cnt_d   = '0;
               state_d = DRAIN;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         // Leave as the last sample sits in S5, so it is accumulated on this same edge.
         DRAIN: if (~|pipe_q.v[3:0]) state_d = HOLD;
         HOLD:  if (grad_ack) state_d = ACCUM;
         default: state_d = ACCUM;
      endcase
   end

   always_comb begin
      acc_d = acc_q;
      if (state_q == HOLD && grad_ack) begin
         acc_d = '0;
      end else if (pipe_q.v[4]) begin
         for (int n = 0; n < NW3; n++)
            acc_d.w3[n*AW +: AW] = acc_q.w3[n*AW +: AW] + AW'($signed(pipe_q.s5_dw3[n*W +: W]));
         for (int n = 0; n < NW2; n++)
            acc_d.w2[n*AW +: AW] = acc_q.w2[n*AW +: AW] + AW'($signed(pipe_q.s5_dw2[n*W +: W]));
         for (int n = 0; n < N_OUT; n++)
            acc_d.b3[n*AW +: AW] = acc_q.b3[n*AW +: AW] + AW'($signed(pipe_q.s5_delta3[n*W +: W]));
         for (int n = 0; n < N_HID; n++)
            acc_d.b2[n*AW +: AW] = acc_q.b2[n*AW +: AW] + AW'($signed(pipe_q.s5_delta2[n*W +: W]));
      end
   end

   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         state_q <= ACCUM;
         cnt_q   <= '0;
         pipe_q  <= '0;
         acc_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pipe_q  <= pipe_d;
         acc_q   <= acc_d;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NW3; gi = gi + 1) begin : g_w3
         assign grad_w3[gi*W +: W] = sat(wide_t'($signed(acc_q.w3[gi*AW +: AW])));
      end
      for (gi = 0; gi < NW2; gi = gi + 1) begin : g_w2
         assign grad_w2[gi*W +: W] = sat(wide_t'($signed(acc_q.w2[gi*AW +: AW])));
      end
      for (gi = 0; gi < N_OUT; gi = gi + 1) begin : g_b3
         assign grad_b3[gi*W +: W] = sat(wide_t'($signed(acc_q.b3[gi*AW +: AW])));
      end
      for (gi = 0; gi < N_HID; gi = gi + 1) begin : g_b2
         assign grad_b2[gi*W +: W] = sat(wide_t'($signed(acc_q.b2[gi*AW +: AW])));
      end
   endgenerate
endmodule

// File: tb/tb_backward_batch.sv
// Bench for backward_batch: directed and random batches are scored against an arithmetic model;
// a second instance exercises a different geometry with BATCH=1.
`timescale 1ns/1ps
module tb_backward_batch;
   localparam int N_IN = 2, N_HID = 3, N_OUT = 2, W = 16, FRAC = 10, BATCH = 4;
   localparam int NW3 = N_HID * N_OUT, NW2 = N_IN * N_HID;
   localparam int GI = 3, GH = 4, GO = 1;
   localparam longint ONE  = longint'(1) << FRAC;
   localparam longint MAXV = (longint'(1) << (W - 1)) - 1;
   localparam longint MINV = -(longint'(1) << (W - 1));

   logic clk = 1'b0;
   logic res;
   logic in_valid, in_ready, grad_valid, grad_ack, busy;
   logic [N_IN*W-1:0]  k;
   logic [N_HID*W-1:0] a2, grad_b2;
   logic [N_OUT*W-1:0] a3, t, grad_b3;
   logic [NW3*W-1:0]   w3, grad_w3;
   logic [NW2*W-1:0]   grad_w2;

   logic g_in_valid, g_in_ready, g_grad_valid, g_grad_ack, g_busy;
   logic [GI*W-1:0]    g_k;
   logic [GH*W-1:0]    g_a2, g_grad_b2;
   logic [GO*W-1:0]    g_a3, g_t, g_grad_b3;
   logic [GH*GO*W-1:0] g_w3, g_grad_w3;
   logic [GI*GH*W-1:0] g_grad_w2;

   always #5 clk = ~clk;

   backward_batch #(.N_IN(N_IN), .N_HID(N_HID), .N_OUT(N_OUT), .W(W), .FRAC(FRAC), .BATCH(BATCH)) dut (
      .clk(clk), .res(res), .in_valid(in_valid), .in_ready(in_ready), .k(k), .a2(a2), .a3(a3), .t(t),
      .w3(w3), .grad_valid(grad_valid), .grad_ack(grad_ack), .grad_w3(grad_w3), .grad_w2(grad_w2),
      .grad_b3(grad_b3), .grad_b2(grad_b2), .busy(busy));

   backward_batch #(.N_IN(GI), .N_HID(GH), .N_OUT(GO), .W(W), .FRAC(FRAC), .BATCH(1)) dut_g (
      .clk(clk), .res(res), .in_valid(g_in_valid), .in_ready(g_in_ready), .k(g_k), .a2(g_a2), .a3(g_a3),
      .t(g_t), .w3(g_w3), .grad_valid(g_grad_valid), .grad_ack(g_grad_ack), .grad_w3(g_grad_w3),
      .grad_w2(g_grad_w2), .grad_b3(g_grad_b3), .grad_b2(g_grad_b2), .busy(g_busy));

   typedef struct packed {
      logic [NW3*W-1:0]   w3;
      logic [NW2*W-1:0]   w2;
      logic [N_OUT*W-1:0] b3;
      logic [N_HID*W-1:0] b2;
   } exp_t;

   exp_t   exp_q[$];
   exp_t   last_exp, mon_e;
   longint m_w3[NW3], m_w2[NW2], m_b3[N_OUT], m_b2[N_HID];
   int     m_cnt = 0, batch_no = 0;
   int     checks = 0, errors = 0;
   bit     seen = 1'b0;

   function automatic longint sat_m(input longint v);
      if (v > MAXV) return MAXV;
      if (v < MINV) return MINV;
      return v;
   endfunction

   // Real-valued product x*y/2^FRAC rounded toward minus infinity, then clamped.
   function automatic longint mul_m(input longint x, input longint y);
      longint p, q;
      p = x * y;
      q = p / ONE;
      if (p < 0 && q * ONE != p) q = q - 1;
      return sat_m(q);
   endfunction

   function automatic longint el(input logic [W-1:0] v);
      return longint'($signed(v));
   endfunction

   function automatic logic [W-1:0] rnd();
      return W'($urandom_range(0, 8191)) - W'(4096);
   endfunction

   task automatic chk(input string name, input longint act, input longint req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endtask

   task automatic chk_vec(input string name, input logic [127:0] act, input logic [127:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   task automatic model_clear();
      foreach (m_w3[n]) m_w3[n] = 0;
      foreach (m_w2[n]) m_w2[n] = 0;
      foreach (m_b3[n]) m_b3[n] = 0;
      foreach (m_b2[n]) m_b2[n] = 0;
      m_cnt = 0;
   endtask

   task automatic model_sample();
      longint d3[N_OUT], d2[N_HID];
      longint s, a;
      exp_t e;
      for (int j = 0; j < N_OUT; j++) begin
         a = el(a3[j*W +: W]);
         d3[j] = mul_m(sat_m(a - el(t[j*W +: W])), mul_m(a, sat_m(ONE - a)));
         m_b3[j] += d3[j];
      end
      for (int i = 0; i < N_HID; i++) begin
         s = 0;
         for (int j = 0; j < N_OUT; j++) s += mul_m(el(w3[(i*N_OUT+j)*W +: W]), d3[j]);
         a = el(a2[i*W +: W]);
         d2[i] = mul_m(sat_m(s), mul_m(a, sat_m(ONE - a)));
         m_b2[i] += d2[i];
         for (int j = 0; j < N_OUT; j++) m_w3[i*N_OUT+j] += mul_m(d3[j], a);
      end
      for (int j = 0; j < N_IN; j++)
         for (int i = 0; i < N_HID; i++) m_w2[j*N_HID+i] += mul_m(d2[i], el(k[j*W +: W]));
      m_cnt++;
      if (m_cnt == BATCH) begin
         for (int n = 0; n < NW3; n++) e.w3[n*W +: W] = W'(sat_m(m_w3[n]));
         for (int n = 0; n < NW2; n++) e.w2[n*W +: W] = W'(sat_m(m_w2[n]));
         for (int n = 0; n < N_OUT; n++) e.b3[n*W +: W] = W'(sat_m(m_b3[n]));
         for (int n = 0; n < N_HID; n++) e.b2[n*W +: W] = W'(sat_m(m_b2[n]));
         exp_q.push_back(e);
         model_clear();
      end
   endtask

   // Scoreboard monitor: one comparison set per grad_valid episode.
   always @(negedge clk) begin
      if (res || !grad_valid) begin
         seen = 1'b0;
      end else if (!seen) begin
         seen = 1'b1;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard: grad_valid with no expected batch, got b3=%h expected none", grad_b3);
         end else begin
            mon_e = exp_q.pop_front();
            last_exp = mon_e;
            batch_no++;
            chk_vec("grad_w3", grad_w3, mon_e.w3);
            chk_vec("grad_w2", grad_w2, mon_e.w2);
            chk_vec("grad_b3", grad_b3, mon_e.b3);
            chk_vec("grad_b2", grad_b2, mon_e.b2);
            $display("batch %0d: b3=%h b2=%h w3=%h w2=%h", batch_no, grad_b3, grad_b2, grad_w3, grad_w2);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_nominal(input logic [W-1:0] a3v);
      for (int j = 0; j < N_OUT; j++) begin a3[j*W +: W] = a3v; t[j*W +: W] = '0; end
      for (int i = 0; i < N_HID; i++) a2[i*W +: W] = W'(512);
      for (int j = 0; j < N_IN; j++) k[j*W +: W] = W'(1024);
      for (int n = 0; n < NW3; n++) w3[n*W +: W] = W'(1024);
   endtask

   task automatic set_random();
      for (int j = 0; j < N_OUT; j++) begin a3[j*W +: W] = rnd(); t[j*W +: W] = rnd(); end
      for (int i = 0; i < N_HID; i++) a2[i*W +: W] = rnd();
      for (int j = 0; j < N_IN; j++) k[j*W +: W] = rnd();
      for (int n = 0; n < NW3; n++) w3[n*W +: W] = rnd();
   endtask

   task automatic send();
      in_valid = 1'b1;
      if (in_ready) model_sample();
      tick();
   endtask

   task automatic idle();
      in_valid = 1'b0;
      tick();
   endtask

   task automatic wait_grad();
      int n;
      n = 0;
      in_valid = 1'b0;
      while (!grad_valid && n < 40) begin tick(); n++; end
      chk("grad_valid latency", n, 5);
   endtask

   // mode 0 nominal back-to-back, 1 nominal gapped, 2 saturating, 3 random
   task automatic run_batch(input int mode);
      for (int s = 0; s < BATCH; s++) begin
         if (mode == 2) set_nominal(W'(-8192));
         else if (mode == 3) set_random();
         else set_nominal(W'(512));
         send();
         if (s != BATCH - 1) begin
            if (mode == 1) repeat (2) idle();
            else if (mode == 3) repeat ($urandom_range(0, 2)) idle();
         end
      end
      wait_grad();
   endtask

   task automatic chk_consts(input longint b3v, input longint b2v, input longint w3v, input longint w2v);
      for (int n = 0; n < N_OUT; n++) chk("const grad_b3", el(grad_b3[n*W +: W]), b3v);
      for (int n = 0; n < N_HID; n++) chk("const grad_b2", el(grad_b2[n*W +: W]), b2v);
      for (int n = 0; n < NW3; n++) chk("const grad_w3", el(grad_w3[n*W +: W]), w3v);
      for (int n = 0; n < NW2; n++) chk("const grad_w2", el(grad_w2[n*W +: W]), w2v);
   endtask

   task automatic hold_phase(input int cycles, input bit junk);
      for (int c = 0; c < cycles; c++) begin
         if (junk) begin set_random(); in_valid = 1'b1; end
         tick();
         chk("hold grad_valid", grad_valid, 1);
         chk("hold in_ready", in_ready, 0);
         chk("hold busy", busy, 1);
         chk_vec("hold grad_b3", grad_b3, last_exp.b3);
         chk_vec("hold grad_w2", grad_w2, last_exp.w2);
      end
      in_valid = 1'b0;
   endtask

   task automatic ack(input bit with_sample);
      grad_ack = 1'b1;
      if (with_sample) begin
         set_random();
         in_valid = 1'b1;
         chk("ack in_ready", in_ready, 0);
      end
      tick();
      grad_ack = 1'b0;
      in_valid = 1'b0;
      chk("post-ack grad_valid", grad_valid, 0);
      chk("post-ack in_ready", in_ready, 1);
      chk("post-ack busy", busy, 0);
      chk_vec("post-ack grad_b3", grad_b3, 0);
      chk_vec("post-ack grad_w3", grad_w3, 0);
   endtask

   initial begin
      int n;
      res = 1'b1; in_valid = 1'b0; grad_ack = 1'b0;
      k = '0; a2 = '0; a3 = '0; t = '0; w3 = '0;
      g_in_valid = 1'b0; g_grad_ack = 1'b0;
      g_k = '0; g_a2 = '0; g_a3 = '0; g_t = '0; g_w3 = '0;
      model_clear();
      tick(); tick();
      chk("reset in_ready", in_ready, 1);
      chk("reset grad_valid", grad_valid, 0);
      chk("reset busy", busy, 0);
      chk_vec("reset grad_b3", grad_b3, 0);
      chk_vec("reset grad_w2", grad_w2, 0);
      chk("reset geo in_ready", g_in_ready, 1);
      res = 1'b0;
      tick();

      // nominal batch
      run_batch(0);
      chk_consts(512, 256, 256, 256);
      ack(1'b0);

      // handshake: long hold with ignored samples, then ack colliding with a sample
      run_batch(0);
      hold_phase(10, 1'b1);
      ack(1'b1);
      run_batch(3);
      hold_phase(1, 1'b0);
      ack(1'b0);

      // saturation
      run_batch(2);
      for (int j = 0; j < N_OUT; j++) chk("sat grad_b3", el(grad_b3[j*W +: W]), 32767);
      ack(1'b0);

      // gapped input
      run_batch(1);
      chk_consts(512, 256, 256, 256);
      hold_phase(2, 1'b0);
      ack(1'b0);

      // reset two cycles into DRAIN
      set_nominal(W'(512));
      for (int s = 0; s < BATCH; s++) send();
      in_valid = 1'b0;
      tick(); tick();
      res = 1'b1;
      #1;
      chk("midreset in_ready", in_ready, 1);
      chk("midreset grad_valid", grad_valid, 0);
      chk("midreset busy", busy, 0);
      chk_vec("midreset grad_w3", grad_w3, 0);
      chk_vec("midreset grad_w2", grad_w2, 0);
      chk_vec("midreset grad_b3", grad_b3, 0);
      chk_vec("midreset grad_b2", grad_b2, 0);
      model_clear();
      exp_q.delete();
      tick();
      res = 1'b0;
      tick();
      run_batch(0);
      chk_consts(512, 256, 256, 256);
      ack(1'b0);

      // random batches
      for (int b = 0; b < 6; b++) begin
         run_batch(3);
         hold_phase($urandom_range(0, 3), 1'($urandom_range(0, 1)));
         ack(1'($urandom_range(0, 1)));
      end

      // alternate geometry, single-sample batch
      for (int i = 0; i < GH; i++) g_a2[i*W +: W] = W'(512);
      for (int j = 0; j < GI; j++) g_k[j*W +: W] = W'(1024);
      for (int n2 = 0; n2 < GH*GO; n2++) g_w3[n2*W +: W] = W'(1024);
      g_a3 = W'(512);
      g_t  = '0;
      chk("geo in_ready", g_in_ready, 1);
      g_in_valid = 1'b1;
      tick();
      g_in_valid = 1'b0;
      n = 0;
      while (!g_grad_valid && n < 40) begin tick(); n++; end
      chk("geo latency", n, 5);
      chk("geo grad_b3", el(g_grad_b3), 128);
      for (int i = 0; i < GH; i++) chk("geo grad_b2", el(g_grad_b2[i*W +: W]), 32);
      for (int i = 0; i < GH*GO; i++) chk("geo grad_w3", el(g_grad_w3[i*W +: W]), 64);
      for (int i = 0; i < GI*GH; i++) chk("geo grad_w2", el(g_grad_w2[i*W +: W]), 32);
      g_grad_ack = 1'b1;
      tick();
      g_grad_ack = 1'b0;
      chk("geo post-ack grad_valid", g_grad_valid, 0);
      chk("geo post-ack grad_b3", el(g_grad_b3), 0);

      tick();
      chk("scoreboard drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
